// File: rtl/mpu9250_pkg.sv
// Shared constants for the MPU9250 sample path: FSM encoding, register map
// addresses and the default read-engine stall limit.
package mpu9250_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [7:0] ACCEL_XOUT_H    = 8'h3B;
  localparam logic [7:0] GYRO_XOUT_H     = 8'h43;
  localparam int         DEFAULT_TIMEOUT = 50000;

endpackage

// File: rtl/mpu_sample_sched_if.sv
// Register-read request channel between the sample scheduler (master) and the
// MPU9250 I2C read engine (slave).
interface mpu_sample_sched_if;

  // oRdReq rises with oRdAddr stable and stays high, address unchanged, until
  // the engine returns a single-cycle iRdAck with iRdData valid in that cycle.
  logic       oRdReq;
  logic [7:0] oRdAddr;
  logic       iRdAck;
  logic [7:0] iRdData;

  modport master (output oRdReq, output oRdAddr, input iRdAck, input iRdData);
  modport slave  (input oRdReq, input oRdAddr, output iRdAck, output iRdData);

endinterface

// File: rtl/tick_edge_det.sv
// Rising-edge detector for the divided rate clock. History resets high so a
// tick already asserted when reset releases is not mistaken for an edge.
module tick_edge_det (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_tick,
  output logic o_edge
);

  logic r_tick_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_tick_q <= 1'b1;
    else       r_tick_q <= i_tick;
  end

  assign o_edge = i_tick & ~r_tick_q;

endmodule

// File: rtl/mpu_sample_sched.sv
// Turns each rate-clock edge into a burst of single-byte MPU9250 register reads
// and publishes the assembled big-endian 16-bit words as one packed sample.
module mpu_sample_sched
  import mpu9250_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR = ACCEL_XOUT_H,
  parameter int         NUM_WORDS = 3,
  parameter int         TIMEOUT   = DEFAULT_TIMEOUT
) (
  input  logic                   iClk50M,
  input  logic                   iRst,
  input  logic                   iTick,
  input  logic                   iEnable,
  input  logic                   iClrFlags,
  mpu_sample_sched_if.master     rd,
  output logic [16*NUM_WORDS-1:0] oData,
  output logic                   oValid,
  output logic                   oBusy,
  output logic                   oOverrun,
  output logic                   oTimeout,
  output logic [15:0]            oSampleCnt,
  output state_e                 oDbgState
);

  localparam int NUM_BYTES = 2 * NUM_WORDS;
  localparam int IDX_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam int TO_W      = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

  state_e                 r_state;
  logic [IDX_W-1:0]       r_idx;
  logic [TO_W-1:0]        r_to_cnt;
  logic [16*NUM_WORDS-1:0] r_asm;
  logic [16*NUM_WORDS-1:0] r_data;
  logic                   r_rd_req;
  logic [7:0]             r_rd_addr;
  logic                   r_valid;
  logic                   r_overrun;
  logic                   r_timeout;
  logic [15:0]            r_sample_cnt;

  logic                   w_edge;
  logic [16*NUM_WORDS-1:0] w_asm_next;

  tick_edge_det u_tick_edge (
    .i_clk  (iClk50M),
    .i_rst  (iRst),
    .i_tick (iTick),
    .o_edge (w_edge)
  );

  // Even byte index is the high byte of word idx/2, odd index its low byte.
  always_comb begin
    w_asm_next = r_asm;
    for (int b = 0; b < NUM_BYTES; b++) begin
      if (r_idx == IDX_W'(b)) w_asm_next[16*(b/2) + 8*(1-(b%2)) +: 8] = rd.iRdData;
    end
  end

  always_ff @(posedge iClk50M) begin
    if (iRst) begin
      r_state      <= IDLE;
      r_idx        <= '0;
      r_to_cnt     <= '0;
      r_asm        <= '0;
      r_data       <= '0;
      r_rd_req     <= 1'b0;
      r_rd_addr    <= 8'h00;
      r_valid      <= 1'b0;
      r_overrun    <= 1'b0;
      r_timeout    <= 1'b0;
      r_sample_cnt <= 16'h0000;
    end else begin
      r_valid <= 1'b0;
      if (iClrFlags) begin
        r_overrun <= 1'b0;
        r_timeout <= 1'b0;
      end
      // Later assignment wins, so a same-cycle set beats the clear.
      if (w_edge && (r_state != IDLE)) r_overrun <= 1'b1;

      case (r_state)
        IDLE: begin
          if (w_edge && iEnable) begin
            r_idx     <= '0;
            r_rd_addr <= BASE_ADDR;
            r_state   <= SETUP;
          end
        end
        SETUP: begin
          r_rd_req <= 1'b1;
          r_to_cnt <= '0;
          r_state  <= WAIT;
        end
        WAIT: begin
          if (rd.iRdAck) begin
            r_asm    <= w_asm_next;
            r_rd_req <= 1'b0;
            if (r_idx == LAST_IDX) begin
              r_data       <= w_asm_next;
              r_valid      <= 1'b1;
              r_sample_cnt <= r_sample_cnt + 16'd1;
              r_state      <= DONE;
            end else begin
              r_idx     <= r_idx + IDX_W'(1);
              r_rd_addr <= BASE_ADDR + 8'(r_idx) + 8'd1;
              r_state   <= SETUP;
            end
          end else if (r_to_cnt == TO_LAST) begin
            r_rd_req  <= 1'b0;
            r_timeout <= 1'b1;
            r_state   <= IDLE;
          end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rd.oRdReq  = r_rd_req;
  assign rd.oRdAddr = r_rd_addr;
  assign oData      = r_data;
  assign oValid     = r_valid;
  assign oBusy      = (r_state != IDLE);
  assign oOverrun   = r_overrun;
  assign oTimeout   = r_timeout;
  assign oSampleCnt = r_sample_cnt;
  assign oDbgState  = r_state;

endmodule
